sakebi_rmii_tx: RTL



---
 rtl/sakebi_pkg.sv | 32 +++
 rtl/sakebi_crc32_d2.sv | 30 +++
 rtl/sakebi_rmii_tx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sakebi_pkg.sv
// Shared definitions for the sakebi RMII transmit/receive pair: FSM states,
// framing dibits and the CRC-32 constants used for the Ethernet FCS.
package sakebi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_FCS,
        S_IFG
    } sakebi_state_t;

    localparam logic [1:0]  SAKEBI_PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  SAKEBI_SFD_DIBIT      = 2'b11;
    localparam logic [31:0] SAKEBI_CRC32_POLY     = 32'hEDB88320;
    localparam logic [31:0] SAKEBI_CRC32_INIT     = 32'hFFFFFFFF;

    // Reflected CRC-32 advanced by one dibit, bit 0 goes out on the wire first.
    function automatic logic [31:0] sakebi_crc32_dibit(input logic [31:0] crc_in,
                                                       input logic [1:0]  dibit);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ dibit[i])
                c = (c >> 1) ^ SAKEBI_CRC32_POLY;
            else
                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/sakebi_crc32_d2.sv
// Dibit-serial CRC-32 for the Ethernet FCS. The crc output already folds in
// the dibit presented this cycle when enable is high (look-ahead value).
module sakebi_crc32_d2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [1:0]  dibit,
    output logic [31:0] crc
);
    import sakebi_pkg::*;

    logic [31:0] crc_q;

    always_comb begin
        crc = crc_q;
        if (enable)
            crc = sakebi_crc32_dibit(crc_q, dibit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc_q <= SAKEBI_CRC32_INIT;
        else if (clear)
            crc_q <= SAKEBI_CRC32_INIT;
        else
            crc_q <= crc;
    end

endmodule

// File: rtl/sakebi_rmii_tx.sv
// AXI4-Stream byte stream to 100 Mb/s RMII transmitter (preamble, SFD, payload, IFG).
// Define SAKEBI_RMII_TX_FCS_EN to append a CRC-32 FCS after the payload.
module sakebi_rmii_tx #(
    parameter int IFG_DIBITS      = 48,
    parameter int PREAMBLE_DIBITS = 31
) (
    input  logic       i_axis_ACLK,
    input  logic       i_axis_ARESETn,
    input  logic       i_axis_TVALID,
    output logic       o_axis_TREADY,
    input  logic [7:0] i_axis_TDATA,
    input  logic       i_axis_TLAST,
    output logic       o_rmii_TX_EN,
    output logic [1:0] o_rmii_TXD,
    output logic       o_tx_busy,
    output logic       o_tx_underrun
);
    import sakebi_pkg::*;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PREAMBLE_DIBITS - 1);
    localparam logic [CNT_W-1:0] SFD_IDX    = CNT_W'(PREAMBLE_DIBITS);
    localparam logic [CNT_W-1:0] DIBIT_LAST = CNT_W'(3);
    // The single IDLE cycle also counts toward the gap on the wire.
    localparam logic [CNT_W-1:0] IFG_LAST   = CNT_W'(IFG_DIBITS - 2);

    sakebi_state_t    state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [29:0]      shreg, shreg_n;
    logic             last_byte, last_n;
    logic             tx_en, tx_en_n;
    logic [1:0]       txd, txd_n;
    logic             underrun, underrun_n;
    logic             busy;
    logic             tready;

`ifdef SAKEBI_RMII_TX_FCS_EN
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(15);

    logic [31:0] crc_word;
    logic [31:0] fcs_word;

    // The dibit on the wire is the one folded into the CRC.
    sakebi_crc32_d2 u_crc (
        .clk    (i_axis_ACLK),
        .rst_n  (i_axis_ARESETn),
        .clear  (state == S_PREAMBLE),
        .enable (state == S_DATA),
        .dibit  (txd),
        .crc    (crc_word)
    );

    assign fcs_word = ~crc_word;
`endif

    always_comb begin
        tready = 1'b0;
        if (state == S_PREAMBLE && cnt == SFD_IDX)
            tready = 1'b1;
        if (state == S_DATA && cnt == DIBIT_LAST && !last_byte)
            tready = 1'b1;
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shreg_n    = shreg;
        last_n     = last_byte;
        tx_en_n    = tx_en;
        txd_n      = txd;
        underrun_n = 1'b0;

        case (state)
            S_IDLE: begin
                tx_en_n = 1'b0;
                txd_n   = 2'b00;
                if (i_axis_TVALID) begin
                    state_n = S_PREAMBLE;
                    cnt_n   = '0;
                    tx_en_n = 1'b1;
                    txd_n   = SAKEBI_PREAMBLE_DIBIT;
                end
            end
            S_PREAMBLE: begin
                if (cnt != SFD_IDX) begin
                    cnt_n = cnt + 1'b1;
                    txd_n = (cnt == PRE_LAST) ? SAKEBI_SFD_DIBIT : SAKEBI_PREAMBLE_DIBIT;
                end
            end
            S_DATA: begin
                if (cnt != DIBIT_LAST) begin
                    cnt_n   = cnt + 1'b1;
                    txd_n   = shreg[1:0];
                    shreg_n = shreg >> 2;
                end else if (last_byte) begin
`ifdef SAKEBI_RMII_TX_FCS_EN
                    state_n = S_FCS;
                    cnt_n   = '0;
                    txd_n   = fcs_word[1:0];
                    shreg_n = fcs_word[31:2];
`else
                    state_n = S_IFG;
                    cnt_n   = '0;
                    tx_en_n = 1'b0;
                    txd_n   = 2'b00;
`endif
                end
            end
`ifdef SAKEBI_RMII_TX_FCS_EN
            S_FCS: begin
                if (cnt == FCS_LAST) begin
                    state_n = S_IFG;
                    cnt_n   = '0;
                    tx_en_n = 1'b0;
                    txd_n   = 2'b00;
                end else begin
                    cnt_n   = cnt + 1'b1;
                    txd_n   = shreg[1:0];
                    shreg_n = shreg >> 2;
                end
            end
`endif
            S_IFG: begin
                if (cnt == IFG_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                tx_en_n = 1'b0;
                txd_n   = 2'b00;
            end
        endcase

        // Byte handoff: either the next byte's first dibit follows seamlessly,
        // or the frame is cut short and the PHY sees TX_EN drop.
        if (tready) begin
            if (i_axis_TVALID) begin
                state_n = S_DATA;
                cnt_n   = '0;
                txd_n   = i_axis_TDATA[1:0];
                shreg_n = {22'd0, i_axis_TDATA[7:2]};
                last_n  = i_axis_TLAST;
            end else begin
                state_n    = S_IFG;
                cnt_n      = '0;
                tx_en_n    = 1'b0;
                txd_n      = 2'b00;
                underrun_n = 1'b1;
            end
        end
    end

    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            last_byte <= 1'b0;
            tx_en     <= 1'b0;
            txd       <= 2'b00;
            underrun  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            last_byte <= last_n;
            tx_en     <= tx_en_n;
            txd       <= txd_n;
            underrun  <= underrun_n;
            busy      <= (state_n != S_IDLE);
        end
    end

    assign o_axis_TREADY = tready;
    assign o_rmii_TX_EN  = tx_en;
    assign o_rmii_TXD    = txd;
    assign o_tx_busy     = busy;
    assign o_tx_underrun = underrun;

endmodule
